// File: rtl/overlay_control_hls_deadlock_pkg.sv
// Shared definitions for the HLS deadlock detector: FSM encoding and default sizing.
package overlay_control_hls_deadlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HOLD   = 2'd3
    } det_state_e;

    localparam int unsigned DEF_N_MON  = 4;
    localparam int unsigned DEF_THRESH = 1024;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned DEF_TS_W   = 32;

    // Index width for an n-entry mask; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/overlay_control_hls_deadlock_prio_enc.sv
// Priority encoder: index of the lowest set bit of mask_i, plus an any-set flag.
module overlay_control_hls_deadlock_prio_enc
    import overlay_control_hls_deadlock_pkg::*;
#(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        any_o = |mask_i;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/overlay_control_hls_deadlock_detector.sv
// Watches the HLS monitor block flags, declares a sticky deadlock after THRESH
// consecutive blocked cycles, and offers a one-shot report over valid/ready.
module overlay_control_hls_deadlock_detector
    import overlay_control_hls_deadlock_pkg::*;
#(
    parameter  int unsigned N_MON  = DEF_N_MON,
    parameter  int unsigned THRESH = DEF_THRESH,
    parameter  int unsigned CNT_W  = DEF_CNT_W,
    parameter  int unsigned TS_W   = DEF_TS_W,
    localparam int unsigned IDX_W  = idx_width(N_MON)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_MON-1:0] mon_block_i,
    input  logic             clear_i,
    output logic             deadlock_o,
    output logic             report_valid_o,
    input  logic             report_ready_i,
    output logic [N_MON-1:0] report_mask_o,
    output logic [IDX_W-1:0] report_idx_o,
    output logic [TS_W-1:0]  report_cycle_o
);

    det_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   start_ts_q, start_ts_d;
    logic              deadlock_q, deadlock_d;
    logic              valid_q, valid_d;
    logic [N_MON-1:0]  mask_q, mask_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TS_W-1:0]   cycle_q, cycle_d;

    logic              any_blk;
    logic [IDX_W-1:0]  blk_idx;
    logic              last_cycle;

    overlay_control_hls_deadlock_prio_enc #(
        .N (N_MON)
    ) u_prio_enc (
        .mask_i (mon_block_i),
        .idx_o  (blk_idx),
        .any_o  (any_blk)
    );

    // This blocked cycle is the THRESH-th of the current window.
    assign last_cycle = any_blk && (cnt_q == CNT_W'(THRESH - 1));

    // Free-running timestamp; only reset touches it.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides everything, including a pending handshake.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (any_blk)        state_d = ST_ARMED;
                ST_ARMED:  if (!any_blk)       state_d = ST_IDLE;
                           else if (last_cycle) state_d = ST_REPORT;
                ST_REPORT: if (report_ready_i) state_d = ST_HOLD;
                ST_HOLD:   state_d = ST_HOLD;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the counter, window start and report registers.
    always_comb begin
        cnt_d      = cnt_q;
        start_ts_d = start_ts_q;
        deadlock_d = deadlock_q;
        valid_d    = valid_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        cycle_d    = cycle_q;
        if (clear_i) begin
            cnt_d      = '0;
            start_ts_d = '0;
            deadlock_d = 1'b0;
            valid_d    = 1'b0;
            mask_d     = '0;
            idx_d      = '0;
            cycle_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_blk) begin
                        cnt_d      = CNT_W'(1);
                        start_ts_d = ts_q;
                    end
                end
                ST_ARMED: begin
                    if (!any_blk) begin
                        cnt_d = '0;
                    end else if (last_cycle) begin
                        cnt_d      = '0;
                        mask_d     = mon_block_i;
                        idx_d      = blk_idx;
                        cycle_d    = start_ts_q;
                        deadlock_d = 1'b1;
                        valid_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (report_ready_i) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Counter, window start and report registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            start_ts_q <= '0;
            deadlock_q <= 1'b0;
            valid_q    <= 1'b0;
            mask_q     <= '0;
            idx_q      <= '0;
            cycle_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            start_ts_q <= start_ts_d;
            deadlock_q <= deadlock_d;
            valid_q    <= valid_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            cycle_q    <= cycle_d;
        end
    end

    assign deadlock_o     = deadlock_q;
    assign report_valid_o = valid_q;
    assign report_mask_o  = mask_q;
    assign report_idx_o   = idx_q;
    assign report_cycle_o = cycle_q;

endmodule

// File: tb/tb_overlay_control_hls_deadlock_detector.sv
// Bench for the HLS deadlock detector: directed scenarios plus random traffic,
// all checked every cycle against a run-length model of the detector.
module tb_overlay_control_hls_deadlock_detector;

    localparam int unsigned N_MON  = 4;
    localparam int unsigned THRESH = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TS_W   = 4;
    localparam int unsigned IDX_W  = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N_MON-1:0] mon_block = '0;
    logic             clear = 1'b0;
    logic             report_ready = 1'b0;
    logic             deadlock;
    logic             report_valid;
    logic [N_MON-1:0] report_mask;
    logic [IDX_W-1:0] report_idx;
    logic [TS_W-1:0]  report_cycle;

    always #5 clock = ~clock;

    overlay_control_hls_deadlock_detector #(
        .N_MON  (N_MON),
        .THRESH (THRESH),
        .CNT_W  (CNT_W),
        .TS_W   (TS_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mon_block_i    (mon_block),
        .clear_i        (clear),
        .deadlock_o     (deadlock),
        .report_valid_o (report_valid),
        .report_ready_i (report_ready),
        .report_mask_o  (report_mask),
        .report_idx_o   (report_idx),
        .report_cycle_o (report_cycle)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: length of the current blocked run, and the report it produced.
    int               m_run;
    logic             m_dead;
    logic             m_valid;
    logic [N_MON-1:0] m_mask;
    logic [IDX_W-1:0] m_idx;
    logic [TS_W-1:0]  m_cycle;
    logic [TS_W-1:0]  m_start;
    logic [TS_W-1:0]  m_ts;

    function automatic logic [IDX_W-1:0] lowest(input logic [N_MON-1:0] m);
        for (int i = 0; i < int'(N_MON); i++) begin
            if (m[i]) return IDX_W'(i);
        end
        return '0;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_run = 0; m_dead = 0; m_valid = 0;
            m_mask = '0; m_idx = '0; m_cycle = '0; m_start = '0; m_ts = '0;
        end else begin
            if (clear) begin
                m_run = 0; m_dead = 0; m_valid = 0;
                m_mask = '0; m_idx = '0; m_cycle = '0;
            end else if (!m_dead) begin
                if (mon_block != '0) begin
                    if (m_run == 0) m_start = m_ts;
                    m_run++;
                    if (m_run == int'(THRESH)) begin
                        m_dead  = 1;
                        m_valid = 1;
                        m_mask  = mon_block;
                        m_idx   = lowest(mon_block);
                        m_cycle = m_start;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (m_valid && report_ready) begin
                m_valid = 0;
            end
            m_ts = m_ts + TS_W'(1);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("deadlock", 32'(deadlock), 32'(m_dead));
            chk("valid",    32'(report_valid), 32'(m_valid));
            chk("mask",     32'(report_mask), 32'(m_mask));
            chk("idx",      32'(report_idx), 32'(m_idx));
            chk("cycle",    32'(report_cycle), 32'(m_cycle));
        end
    end

    task automatic step(input logic [N_MON-1:0] mb, input logic clr, input logic rdy, input logic rst);
        mon_block    = mb;
        clear        = clr;
        report_ready = rdy;
        reset        = rst;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_deadlock"}, 32'(deadlock), 32'd0);
        chk({tag, "_valid"},    32'(report_valid), 32'd0);
        chk({tag, "_mask"},     32'(report_mask), 32'd0);
        chk({tag, "_idx"},      32'(report_idx), 32'd0);
        chk({tag, "_cycle"},    32'(report_cycle), 32'd0);
    endtask

    initial begin
        logic [N_MON-1:0] mb;
        logic clr, rdy, rst;

        @(negedge clock);
        step('0, 0, 0, 1);
        chk_en = 1'b1;
        chk_all_zero("reset");

        // 1: single monitor blocked for THRESH cycles, window starts at ts=0
        repeat (3) step(4'b0001, 0, 0, 0);
        chk("t1_early_deadlock", 32'(deadlock), 32'd0);
        step(4'b0001, 0, 0, 0);
        chk("t1_deadlock", 32'(deadlock), 32'd1);
        chk("t1_valid",    32'(report_valid), 32'd1);
        chk("t1_mask",     32'(report_mask), 32'h1);
        chk("t1_idx",      32'(report_idx), 32'd0);
        chk("t1_cycle",    32'(report_cycle), 32'd0);
        step('0, 1, 0, 0);
        chk_all_zero("t1_clear");

        // 2: a one-cycle gap restarts the window
        repeat (3) step(4'b0100, 0, 0, 0);
        step('0, 0, 0, 0);
        repeat (3) step(4'b0100, 0, 0, 0);
        chk("t2_deadlock", 32'(deadlock), 32'd0);
        step('0, 1, 0, 0);

        // 3: changing set of blocked bits keeps one window
        step(4'b0010, 0, 0, 0);
        step(4'b0110, 0, 0, 0);
        step(4'b0100, 0, 0, 0);
        step(4'b1100, 0, 0, 0);
        chk("t3_deadlock", 32'(deadlock), 32'd1);
        chk("t3_mask",     32'(report_mask), 32'hc);
        chk("t3_idx",      32'(report_idx), 32'd2);

        // 4: consumer stalls, then accepts
        repeat (10) step(4'b1111, 0, 0, 0);
        chk("t4_valid_held", 32'(report_valid), 32'd1);
        chk("t4_mask_held",  32'(report_mask), 32'hc);
        step('0, 0, 1, 0);
        chk("t4_valid_drop", 32'(report_valid), 32'd0);
        chk("t4_deadlock",   32'(deadlock), 32'd1);
        repeat (3) step(4'b0001, 0, 1, 0);
        step('0, 1, 0, 0);

        // 5: clear wins over ready, then re-declare
        repeat (4) step(4'b0001, 0, 0, 0);
        chk("t5_declared", 32'(deadlock), 32'd1);
        step(4'b0001, 1, 1, 0);
        chk("t5_deadlock_clr", 32'(deadlock), 32'd0);
        chk("t5_valid_clr",    32'(report_valid), 32'd0);
        repeat (3) step(4'b0001, 0, 0, 0);
        chk("t5_not_yet", 32'(deadlock), 32'd0);
        step(4'b0001, 0, 0, 0);
        chk("t5_redeclare", 32'(deadlock), 32'd1);

        // 6: window straddling the timestamp wrap, then reset mid-window
        step('0, 0, 0, 1);
        repeat (14) step('0, 0, 0, 0);
        repeat (4) step(4'b0010, 0, 0, 0);
        chk("t6_deadlock", 32'(deadlock), 32'd1);
        chk("t6_cycle",    32'(report_cycle), 32'd14);
        chk("t6_idx",      32'(report_idx), 32'd1);
        step('0, 1, 0, 0);
        repeat (2) step(4'b1000, 0, 0, 0);
        step(4'b1000, 0, 0, 1);
        chk_all_zero("t6_reset");
        repeat (3) step(4'b1000, 0, 0, 0);
        chk("t6_rearm_wait", 32'(deadlock), 32'd0);
        step(4'b1000, 0, 0, 0);
        chk("t6_rearm", 32'(deadlock), 32'd1);
        chk("t6_rearm_cycle", 32'(report_cycle), 32'd0);

        // Random traffic
        repeat (3000) begin
            mb  = ($urandom_range(0, 9) < 8) ? N_MON'($urandom) : '0;
            clr = ($urandom_range(0, 59) == 0);
            rdy = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step(mb, clr, rdy, rst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
